// File: rtl/cache_refill_controller.sv
// Refill/flush sequencer for the direct-mapped instruction cache: fetches a missing line
// beat by beat from instruction memory, writes it into the arrays, and walks all lines on flush.
module cache_refill_controller #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INDEX_BITS  = 5,
   parameter int OFFSET_BITS = 4,
   parameter int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          miss_req,
   input  logic [ADDR_WIDTH-1:0]         miss_addr,
   input  logic                          flush_req,
   output logic                          mem_req,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic                          mem_ack,
   input  logic [31:0]                   mem_rdata,
   output logic                          fill_we,
   output logic [INDEX_BITS-1:0]         fill_index,
   output logic [TAG_BITS-1:0]           fill_tag,
   output logic                          fill_valid,
   output logic [(8<<OFFSET_BITS)-1:0]   fill_data,
   output logic                          busy,
   output logic                          refill_done,
   output logic                          flush_done
);

   localparam int BEAT_BITS = OFFSET_BITS - 2;
   localparam int WORDS     = 1 << BEAT_BITS;
   localparam int LINE_BITS = ADDR_WIDTH - OFFSET_BITS;
   localparam logic [BEAT_BITS-1:0]  LAST_BEAT  = BEAT_BITS'(WORDS - 1);
   localparam logic [INDEX_BITS-1:0] LAST_INDEX = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WRITE, ST_FLUSH} state_t;

   state_t                 state_reg, state_next;
   logic [BEAT_BITS-1:0]   beat_reg, beat_next;
   logic [INDEX_BITS-1:0]  flush_cnt_reg, flush_cnt_next;
   logic                   flush_pending_reg, flush_pending_next;
   logic [LINE_BITS-1:0]   line_base_reg, line_base_next;
   logic [31:0]            word_reg [WORDS];

   // Byte offset of the miss address is irrelevant: the whole line is fetched.
   logic unused_offset_bits;
   assign unused_offset_bits = ^miss_addr[OFFSET_BITS-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg         <= ST_IDLE;
         beat_reg          <= '0;
         flush_cnt_reg     <= '0;
         flush_pending_reg <= 1'b0;
         line_base_reg     <= '0;
      end else begin
         state_reg         <= state_next;
         beat_reg          <= beat_next;
         flush_cnt_reg     <= flush_cnt_next;
         flush_pending_reg <= flush_pending_next;
         line_base_reg     <= line_base_next;
      end
   end

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               word_reg[gi] <= '0;
            end else if (state_reg == ST_FETCH && mem_ack && beat_reg == BEAT_BITS'(gi)) begin
               word_reg[gi] <= mem_rdata;
            end
         end
         assign fill_data[32*gi +: 32] = (state_reg == ST_WRITE) ? word_reg[gi] : 32'h0;
      end
   endgenerate

   assign busy = (state_reg != ST_IDLE);

   always_comb begin
      state_next         = state_reg;
      beat_next          = beat_reg;
      flush_cnt_next     = flush_cnt_reg;
      flush_pending_next = flush_pending_reg;
      line_base_next     = line_base_reg;
      mem_req            = 1'b0;
      mem_addr           = '0;
      fill_we            = 1'b0;
      fill_index         = '0;
      fill_tag           = '0;
      fill_valid         = 1'b0;
      refill_done        = 1'b0;
      flush_done         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (flush_req || flush_pending_reg) begin
               state_next         = ST_FLUSH;
               flush_cnt_next     = '0;
               flush_pending_next = 1'b0;
            end else if (miss_req) begin
               state_next     = ST_FETCH;
               line_base_next = miss_addr[ADDR_WIDTH-1:OFFSET_BITS];
               beat_next      = '0;
            end
         end
         ST_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = {line_base_reg, beat_reg, 2'b00};
            if (flush_req) begin
               flush_pending_next = 1'b1;
            end
            if (mem_ack) begin
               if (beat_reg == LAST_BEAT) begin
                  state_next = ST_WRITE;
               end else begin
                  beat_next = beat_reg + 1'b1;
               end
            end
         end
         ST_WRITE: begin
            fill_we     = 1'b1;
            fill_valid  = 1'b1;
            fill_index  = line_base_reg[INDEX_BITS-1:0];
            fill_tag    = line_base_reg[LINE_BITS-1:INDEX_BITS];
            refill_done = 1'b1;
            // A flush that arrived during the refill starts right away, without an IDLE gap.
            if (flush_req || flush_pending_reg) begin
               state_next         = ST_FLUSH;
               flush_cnt_next     = '0;
               flush_pending_next = 1'b0;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            fill_we        = 1'b1;
            fill_index     = flush_cnt_reg;
            flush_cnt_next = flush_cnt_reg + 1'b1;
            if (flush_cnt_reg == LAST_INDEX) begin
               flush_done = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed testbench for cache_refill_controller: refill timing, flush walk, flush/miss interplay, reset abort.
module tb_cache_refill_controller;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          miss_req = 1'b0;
   logic [31:0]   miss_addr = '0;
   logic          flush_req = 1'b0;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic          mem_ack = 1'b0;
   logic [31:0]   mem_rdata = '0;
   logic          fill_we;
   logic [4:0]    fill_index;
   logic [22:0]   fill_tag;
   logic          fill_valid;
   logic [127:0]  fill_data;
   logic          busy;
   logic          refill_done;
   logic          flush_done;

   int pass_cnt = 0;
   int total_cnt = 0;

   cache_refill_controller dut (
      .clock(clock), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
      .flush_req(flush_req), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag),
      .fill_valid(fill_valid), .fill_data(fill_data), .busy(busy),
      .refill_done(refill_done), .flush_done(flush_done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (2) @(negedge clock);
      total_cnt++;
      if ({busy, mem_req, fill_we, fill_valid, refill_done, flush_done} !== 6'b0 || mem_addr !== 32'h0 || fill_data !== 128'h0)
         $display("FAIL reset_outputs: got busy=%b mem_req=%b fill_we=%b mem_addr=%h expected all 0", busy, mem_req, fill_we, mem_addr);
      else pass_cnt++;
      reset = 1'b1;
      @(negedge clock);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_release_idle: got busy=%b expected 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_miss_fast();
      miss_req = 1'b1;
      miss_addr = 32'h0000_2A34;
      for (int b = 0; b < 4; b++) begin
         @(negedge clock);
         total_cnt++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h2A30 + 32'(4*b) || busy !== 1'b1)
            $display("FAIL fast_beat%0d: got mem_req=%b mem_addr=%h expected 1 %h", b, mem_req, mem_addr, 32'h2A30 + 32'(4*b));
         else pass_cnt++;
         mem_ack = 1'b1;
         mem_rdata = 32'hA0 + 32'(b);
         if (b == 1) miss_addr = 32'h0000_FFF0;
      end
      @(negedge clock);
      mem_ack = 1'b0;
      miss_req = 1'b0;
      total_cnt++;
      if (fill_we !== 1'b1 || fill_valid !== 1'b1 || refill_done !== 1'b1 || mem_req !== 1'b0)
         $display("FAIL fast_write_strobes: got we=%b valid=%b done=%b mem_req=%b expected 1 1 1 0", fill_we, fill_valid, refill_done, mem_req);
      else pass_cnt++;
      total_cnt++;
      if (fill_index !== 5'd3 || fill_tag !== 23'h15)
         $display("FAIL fast_write_index_tag: got index=%0d tag=%h expected 3 15", fill_index, fill_tag);
      else pass_cnt++;
      total_cnt++;
      if (fill_data !== 128'h000000A3_000000A2_000000A1_000000A0)
         $display("FAIL fast_write_data: got %h expected 000000a3000000a2000000a1000000a0", fill_data);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (busy !== 1'b0 || fill_we !== 1'b0 || refill_done !== 1'b0 || fill_data !== 128'h0)
         $display("FAIL fast_back_idle: got busy=%b we=%b done=%b expected 0 0 0", busy, fill_we, refill_done);
      else pass_cnt++;
   endtask

   task automatic test_miss_slow();
      int fetch_cycles = 0;
      miss_req = 1'b1;
      miss_addr = 32'h0000_2A34;
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < 4; w++) begin
            @(negedge clock);
            if (mem_req === 1'b1) fetch_cycles++;
            total_cnt++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h2A30 + 32'(4*b))
               $display("FAIL slow_beat%0d_wait%0d: got mem_req=%b mem_addr=%h expected 1 %h", b, w, mem_req, mem_addr, 32'h2A30 + 32'(4*b));
            else pass_cnt++;
            mem_ack = (w == 3);
            mem_rdata = (w == 3) ? 32'hA0 + 32'(b) : 32'hDEAD_BEEF;
         end
      end
      @(negedge clock);
      mem_ack = 1'b1;
      mem_rdata = 32'h1111_1111;
      miss_req = 1'b0;
      total_cnt++;
      if (fetch_cycles != 16) $display("FAIL slow_fetch_cycles: got %0d expected 16", fetch_cycles);
      else pass_cnt++;
      total_cnt++;
      if (fill_we !== 1'b1 || refill_done !== 1'b1 || fill_data !== 128'h000000A3_000000A2_000000A1_000000A0)
         $display("FAIL slow_write: got we=%b done=%b data=%h expected 1 1 000000a3000000a2000000a1000000a0", fill_we, refill_done, fill_data);
      else pass_cnt++;
      @(negedge clock);
      mem_ack = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || mem_req !== 1'b0) $display("FAIL slow_idle_ack_ignored: got busy=%b mem_req=%b expected 0 0", busy, mem_req);
      else pass_cnt++;
   endtask

   task automatic test_flush_idle();
      flush_req = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         flush_req = (i == 5);
         total_cnt++;
         if (fill_we !== 1'b1 || fill_valid !== 1'b0 || fill_index !== 5'(i) || fill_tag !== 23'h0 || fill_data !== 128'h0 || flush_done !== (i == 31))
            $display("FAIL flush_cycle%0d: got we=%b valid=%b index=%0d done=%b expected 1 0 %0d %b", i, fill_we, fill_valid, fill_index, flush_done, i, (i == 31));
         else pass_cnt++;
      end
      repeat (2) begin
         @(negedge clock);
         total_cnt++;
         if (busy !== 1'b0 || fill_we !== 1'b0 || flush_done !== 1'b0)
            $display("FAIL flush_end_idle: got busy=%b we=%b done=%b expected 0 0 0", busy, fill_we, flush_done);
         else pass_cnt++;
      end
   endtask

   task automatic test_flush_during_fetch();
      miss_req = 1'b1;
      miss_addr = 32'h0000_2A34;
      for (int b = 0; b < 4; b++) begin
         @(negedge clock);
         total_cnt++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h2A30 + 32'(4*b))
            $display("FAIL fdf_beat%0d: got mem_req=%b mem_addr=%h expected 1 %h", b, mem_req, mem_addr, 32'h2A30 + 32'(4*b));
         else pass_cnt++;
         flush_req = (b == 1);
         mem_ack = 1'b1;
         mem_rdata = 32'hB0 + 32'(b);
      end
      @(negedge clock);
      mem_ack = 1'b0;
      miss_req = 1'b0;
      total_cnt++;
      if (fill_we !== 1'b1 || fill_valid !== 1'b1 || refill_done !== 1'b1 || fill_data !== 128'h000000B3_000000B2_000000B1_000000B0)
         $display("FAIL fdf_write: got we=%b valid=%b done=%b data=%h expected 1 1 1 000000b3000000b2000000b1000000b0", fill_we, fill_valid, refill_done, fill_data);
      else pass_cnt++;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         total_cnt++;
         if (fill_we !== 1'b1 || fill_valid !== 1'b0 || fill_index !== 5'(i) || busy !== 1'b1 || flush_done !== (i == 31))
            $display("FAIL fdf_flush%0d: got we=%b valid=%b index=%0d done=%b expected 1 0 %0d %b", i, fill_we, fill_valid, fill_index, flush_done, i, (i == 31));
         else pass_cnt++;
      end
      @(negedge clock);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL fdf_idle: got busy=%b expected 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_flush_and_miss();
      flush_req = 1'b1;
      miss_req = 1'b1;
      miss_addr = 32'h1234_5678;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         flush_req = 1'b0;
         total_cnt++;
         if (fill_we !== 1'b1 || fill_valid !== 1'b0 || fill_index !== 5'(i) || mem_req !== 1'b0)
            $display("FAIL fm_flush%0d: got we=%b valid=%b index=%0d mem_req=%b expected 1 0 %0d 0", i, fill_we, fill_valid, fill_index, mem_req, i);
         else pass_cnt++;
      end
      @(negedge clock);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL fm_idle_gap: got busy=%b expected 0", busy);
      else pass_cnt++;
      for (int b = 0; b < 4; b++) begin
         @(negedge clock);
         total_cnt++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h1234_5670 + 32'(4*b))
            $display("FAIL fm_beat%0d: got mem_req=%b mem_addr=%h expected 1 %h", b, mem_req, mem_addr, 32'h1234_5670 + 32'(4*b));
         else pass_cnt++;
         mem_ack = 1'b1;
         mem_rdata = 32'hC0 + 32'(b);
      end
      @(negedge clock);
      mem_ack = 1'b0;
      miss_req = 1'b0;
      total_cnt++;
      if (fill_we !== 1'b1 || fill_index !== 5'd7 || fill_tag !== 23'h091A2B || fill_data !== 128'h000000C3_000000C2_000000C1_000000C0)
         $display("FAIL fm_write: got we=%b index=%0d tag=%h data=%h expected 1 7 091a2b 000000c3000000c2000000c1000000c0", fill_we, fill_index, fill_tag, fill_data);
      else pass_cnt++;
      @(negedge clock);
   endtask

   task automatic test_reset_mid_fetch();
      miss_req = 1'b1;
      miss_addr = 32'h0000_2A34;
      for (int b = 0; b < 2; b++) begin
         @(negedge clock);
         mem_ack = 1'b1;
         mem_rdata = 32'hD0 + 32'(b);
      end
      @(negedge clock);
      mem_ack = 1'b0;
      total_cnt++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h2A38)
         $display("FAIL rst_beat2: got mem_req=%b mem_addr=%h expected 1 00002a38", mem_req, mem_addr);
      else pass_cnt++;
      #1 reset = 1'b0;
      #1;
      total_cnt++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0)
         $display("FAIL rst_immediate: got mem_req=%b busy=%b mem_addr=%h expected 0 0 0", mem_req, busy, mem_addr);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (fill_we !== 1'b0 || busy !== 1'b0 || refill_done !== 1'b0)
         $display("FAIL rst_no_fill: got we=%b busy=%b done=%b expected 0 0 0", fill_we, busy, refill_done);
      else pass_cnt++;
      reset = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clock);
         total_cnt++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h2A30 + 32'(4*b))
            $display("FAIL rst_refetch%0d: got mem_req=%b mem_addr=%h expected 1 %h", b, mem_req, mem_addr, 32'h2A30 + 32'(4*b));
         else pass_cnt++;
         mem_ack = 1'b1;
         mem_rdata = 32'hE0 + 32'(b);
      end
      @(negedge clock);
      mem_ack = 1'b0;
      miss_req = 1'b0;
      total_cnt++;
      if (fill_we !== 1'b1 || fill_index !== 5'd3 || fill_data !== 128'h000000E3_000000E2_000000E1_000000E0)
         $display("FAIL rst_refill_write: got we=%b index=%0d data=%h expected 1 3 000000e3000000e2000000e1000000e0", fill_we, fill_index, fill_data);
      else pass_cnt++;
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_miss_fast();
      test_miss_slow();
      test_flush_idle();
      test_flush_during_fetch();
      test_flush_and_miss();
      test_reset_mid_fetch();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
